// File: rtl/spi_xfer_ctrl_pkg.sv
// spi_pkg: shared definitions for the SPI transfer sequencer.
//   - state_t        : sequencer state encoding
//   - CPOL           : SCLK idle level (mode 0, idle low)
//   - BYTE_W         : bits per SPI byte
//   - EDGES_PER_BYTE : SCLK toggles needed to move one byte
package spi_pkg;

    localparam logic CPOL           = 1'b0;
    localparam int   BYTE_W         = 8;
    localparam int   EDGES_PER_BYTE = 2 * BYTE_W;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        LOAD,
        EN,
        SHIFT,
        BYTE_END,
        CS_HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// spi_xfer_ctrl_if: host, SPI pin and byte-transmitter signals of the
// transfer sequencer, bundled in one place.
//   modport master : the sequencer (drives SPI pins, strobes, host status)
//   modport slave  : the surroundings (host, MISO source, byte transmitter)
// Host side : Start, Len, Byte_Idx, Byte_In, Rx_Data, Rx_Valid, Busy, Done
// SPI pins  : CSn, SCLK, MISO
// Byte tx   : Tx_En, Tx_Data, H2L_Sig, L2H_Sig, Tx_Busy
interface spi_xfer_ctrl_if #(
    parameter int LEN_W = 4
);
    import spi_pkg::*;

    logic              Start;
    logic [LEN_W-1:0]  Len;
    logic [LEN_W-1:0]  Byte_Idx;
    logic [BYTE_W-1:0] Byte_In;
    logic [BYTE_W-1:0] Rx_Data;
    logic              Rx_Valid;
    logic              Busy;
    logic              Done;
    logic              CSn;
    logic              SCLK;
    logic              MISO;
    logic              Tx_En;
    logic [BYTE_W-1:0] Tx_Data;
    logic              H2L_Sig;
    logic              L2H_Sig;
    logic              Tx_Busy;

    modport master (
        input  Start, Len, Byte_In, MISO, Tx_Busy,
        output Byte_Idx, Rx_Data, Rx_Valid, Busy, Done, CSn, SCLK,
               Tx_En, Tx_Data, H2L_Sig, L2H_Sig
    );

    modport slave (
        output Start, Len, Byte_In, MISO, Tx_Busy,
        input  Byte_Idx, Rx_Data, Rx_Valid, Busy, Done, CSn, SCLK,
               Tx_En, Tx_Data, H2L_Sig, L2H_Sig
    );

endinterface

// File: rtl/spi_xfer_ctrl_sclk_gen.sv
// spi_sclk_gen: SCLK generator for one byte.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_run         : advance the half-period counter
//   i_clear       : return counter, edge count and SCLK to idle
//   o_sclk        : serial clock
//   o_h2l, o_l2h  : one-cycle strobes in the cycle before SCLK falls / rises
//   o_byte_last   : strobe coinciding with the final (falling) toggle of a byte
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_clear,
    output logic o_sclk,
    output logic o_h2l,
    output logic o_l2h,
    output logic o_byte_last
);
    import spi_pkg::*;

    localparam int                DIV_W     = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam int                EDGE_W    = $clog2(EDGES_PER_BYTE);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES_PER_BYTE - 1);

    logic [DIV_W-1:0]  r_div;
    logic [EDGE_W-1:0] r_edge;
    logic              r_sclk;
    logic              w_wrap;

    // The strobes are combinational so they sit in the cycle whose closing
    // clock edge toggles SCLK; this keeps them strictly inside SHIFT.
    assign w_wrap      = i_run && (r_div == DIV_LAST);
    assign o_l2h       = w_wrap && (r_sclk == CPOL);
    assign o_h2l       = w_wrap && (r_sclk != CPOL);
    assign o_byte_last = w_wrap && (r_edge == EDGE_LAST);
    assign o_sclk      = r_sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_edge <= '0;
            r_sclk <= CPOL;
        end else if (i_clear) begin
            r_div  <= '0;
            r_edge <= '0;
            r_sclk <= CPOL;
        end else if (i_run) begin
            if (w_wrap) begin
                r_div  <= '0;
                r_sclk <= ~r_sclk;
                // Wraps to zero after the last toggle, ready for the next byte.
                r_edge <= r_edge + EDGE_W'(1);
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: multi-byte, chip-select-framed SPI mode-0 transfer sequencer
// feeding an external byte transmitter.
//   CLK, RSTn : clock, asynchronous active-low reset
//   bus       : spi_xfer_ctrl_if.master
//       host  : Start/Len request, Byte_Idx/Byte_In TX fetch,
//               Rx_Data/Rx_Valid RX bytes, Busy, Done
//       pins  : CSn, SCLK out, MISO in
//       tx    : Tx_En, Tx_Data, H2L_Sig, L2H_Sig out, Tx_Busy in
module spi_xfer_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 4,
    parameter int CS_GAP  = 4
) (
    input  logic            CLK,
    input  logic            RSTn,
    spi_xfer_ctrl_if.master bus
);
    import spi_pkg::*;

    localparam int               GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic [LEN_W-1:0]  w_idx_inc;
    logic [GAP_W-1:0]  r_gap;
    logic              r_more;
    logic [BYTE_W-1:0] r_tx_data;
    logic [BYTE_W-1:0] r_rx_shift;
    logic [BYTE_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              w_gap_done;
    logic              w_run;
    logic              w_clear;
    logic              w_sclk;
    logic              w_h2l;
    logic              w_l2h;
    logic              w_byte_last;

    assign w_gap_done = (r_gap == GAP_LAST);
    assign w_idx_inc  = r_idx + LEN_W'(1);
    assign w_run      = (r_state == SHIFT);
    assign w_clear    = (r_state == EN);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk         (CLK),
        .rst_n       (RSTn),
        .i_run       (w_run),
        .i_clear     (w_clear),
        .o_sclk      (w_sclk),
        .o_h2l       (w_h2l),
        .o_l2h       (w_l2h),
        .o_byte_last (w_byte_last)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (bus.Start && (bus.Len != '0)) w_state_next = CS_SETUP;
            CS_SETUP: if (w_gap_done) w_state_next = LOAD;
            LOAD:     w_state_next = EN;
            EN:       w_state_next = SHIFT;
            SHIFT:    if (w_byte_last) w_state_next = BYTE_END;
            BYTE_END: if (!bus.Tx_Busy) w_state_next = r_more ? LOAD : CS_HOLD;
            CS_HOLD:  if (w_gap_done) w_state_next = DONE;
            DONE:     w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_idx      <= '0;
            r_gap      <= '0;
            r_more     <= 1'b0;
            r_tx_data  <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rx_valid <= w_byte_last;

            if ((r_state == IDLE) && bus.Start && (bus.Len != '0)) begin
                r_len <= bus.Len;
            end

            // One counter times both the CSn setup and the CSn hold gap.
            if (((r_state == CS_SETUP) || (r_state == CS_HOLD)) && !w_gap_done) begin
                r_gap <= r_gap + GAP_W'(1);
            end else begin
                r_gap <= '0;
            end

            if (r_state == LOAD) begin
                r_tx_data <= bus.Byte_In;
            end

            if (w_l2h) begin
                r_rx_shift <= {r_rx_shift[BYTE_W-2:0], bus.MISO};
            end

            // The index advances on entry to BYTE_END rather than on exit so
            // the host already sees the next index for the whole cycle before
            // LOAD, including any Tx_Busy stall.
            if (w_byte_last) begin
                r_rx_data <= r_rx_shift;
                r_more    <= (w_idx_inc != r_len);
                if (w_idx_inc != r_len) begin
                    r_idx <= w_idx_inc;
                end
            end else if ((r_state == CS_HOLD) && w_gap_done) begin
                r_idx <= '0;
            end
        end
    end

    // Frame and status outputs decode the state register directly, so an
    // asynchronous reset releases CSn in the same instant.
    assign bus.CSn      = (r_state == IDLE) || (r_state == DONE);
    assign bus.Busy     = (r_state != IDLE) && (r_state != DONE);
    assign bus.Done     = (r_state == DONE);
    assign bus.Tx_En    = (r_state == EN);
    assign bus.Tx_Data  = r_tx_data;
    assign bus.Byte_Idx = r_idx;
    assign bus.Rx_Data  = r_rx_data;
    assign bus.Rx_Valid = r_rx_valid;
    assign bus.SCLK     = w_sclk;
    assign bus.H2L_Sig  = w_h2l;
    assign bus.L2H_Sig  = w_l2h;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
module tb_spi_xfer_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] tx_mem [16];
    logic       miso_one   = 1'b0;
    logic       force_busy = 1'b0;
    logic [7:0] tx_sh;
    logic [3:0] tx_cnt;

    spi_xfer_ctrl_if #(.LEN_W(4)) bus ();

    spi_xfer_ctrl #(
        .CLK_DIV (4),
        .LEN_W   (4),
        .CS_GAP  (4)
    ) dut (
        .CLK  (clk),
        .RSTn (rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte transmitter model: loads on Tx_En, presents MSB on MOSI, shifts on H2L.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh  <= 8'h00;
            tx_cnt <= 4'd0;
        end else if (bus.Tx_En) begin
            tx_sh  <= bus.Tx_Data;
            tx_cnt <= 4'd8;
        end else if (bus.H2L_Sig && (tx_cnt != 4'd0)) begin
            tx_sh  <= {tx_sh[6:0], 1'b0};
            tx_cnt <= tx_cnt - 4'd1;
        end
    end

    assign bus.MISO    = miso_one ? 1'b1 : tx_sh[7];
    assign bus.Tx_Busy = (tx_cnt != 4'd0) || force_busy;
    assign bus.Byte_In = tx_mem[bus.Byte_Idx];

    // Monitor: records DUT events; tasks compare against expectations.
    logic [7:0] rx_obs  [$];
    logic [3:0] idx_obs [$];
    logic [7:0] txd_obs [$];
    int         txd_chg [$];
    logic [7:0] exp_rx  [$];
    int   done_cnt = 0, h2l_cnt = 0, l2h_cnt = 0, strobe_err = 0;
    int   cs_frames = 0, cs_fall = 0, cs_last_low = 0;
    logic prev_csn = 1'b1;
    logic [7:0] prev_txd = 8'h00;

    always @(negedge clk) begin
        if (bus.Rx_Valid) rx_obs.push_back(bus.Rx_Data);
        if (bus.Done) done_cnt <= done_cnt + 1;
        if (bus.H2L_Sig) h2l_cnt <= h2l_cnt + 1;
        if (bus.L2H_Sig) l2h_cnt <= l2h_cnt + 1;
        if ((bus.H2L_Sig && bus.L2H_Sig) || ((bus.H2L_Sig || bus.L2H_Sig) && bus.CSn))
            strobe_err <= strobe_err + 1;
        if (!bus.CSn) begin
            if (prev_csn) begin
                cs_frames <= cs_frames + 1;
                cs_fall   <= cyc;
            end
            cs_last_low <= cyc;
        end
        prev_csn <= bus.CSn;
        if (bus.Tx_Data !== prev_txd) txd_chg.push_back(cyc);
        prev_txd <= bus.Tx_Data;
        if (bus.Tx_En) begin
            idx_obs.push_back(bus.Byte_Idx);
            txd_obs.push_back(bus.Tx_Data);
        end
    end

    task automatic start_xfer(input logic [3:0] len, output int t0);
        @(posedge clk); #1;
        bus.Start = 1'b1;
        bus.Len   = len;
        t0        = cyc;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        bus.Len   = 4'd0;
    endtask

    // Returns the cycle in which Done was seen, or -1 if the budget expired.
    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.Done) begin
                dc = cyc;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.CSn, bus.SCLK, bus.Busy, bus.Done, bus.Rx_Valid, bus.Tx_En, bus.H2L_Sig, bus.L2H_Sig} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 10000000",
                     {bus.CSn, bus.SCLK, bus.Busy, bus.Done, bus.Rx_Valid, bus.Tx_En, bus.H2L_Sig, bus.L2H_Sig});
        end
        checks++;
        if ({bus.Tx_Data, bus.Rx_Data, bus.Byte_Idx} !== 20'h0) begin
            errors++;
            $display("FAIL reset_data: got %h required 00000", {bus.Tx_Data, bus.Rx_Data, bus.Byte_Idx});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.Busy !== 1'b0 || bus.CSn !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: Busy=%b CSn=%b required 0/1", bus.Busy, bus.CSn);
        end
    endtask

    task automatic test_single_loopback();
        int t0, dc, rx_rd, h0, l0, f0, se0;
        logic [7:0] e;
        tx_mem[0] = 8'hA5; miso_one = 1'b0;
        exp_rx.push_back(8'hA5);
        rx_rd = rx_obs.size(); h0 = h2l_cnt; l0 = l2h_cnt; f0 = cs_frames; se0 = strobe_err;
        start_xfer(4'd1, t0);
        wait_done(300, dc);
        $display("xfer single: len=1 start=%0d done=%0d", t0, dc);
        checks++;
        if (dc - t0 != 76) begin errors++; $display("FAIL single_latency: got %0d required 76", dc - t0); end
        checks++;
        if (rx_obs.size() - rx_rd != 1) begin errors++; $display("FAIL single_rx_count: got %0d required 1", rx_obs.size() - rx_rd); end
        e = exp_rx.pop_front();
        checks++;
        if (rx_obs.size() <= rx_rd || rx_obs[rx_rd] !== e) begin
            errors++; $display("FAIL single_rx_data: got %h required %h", (rx_obs.size() > rx_rd) ? rx_obs[rx_rd] : 8'hxx, e);
        end
        checks++;
        if (h2l_cnt - h0 != 8 || l2h_cnt - l0 != 8) begin
            errors++; $display("FAIL single_edges: got h2l=%0d l2h=%0d required 8/8", h2l_cnt - h0, l2h_cnt - l0);
        end
        checks++;
        if (cs_fall != t0 + 1 || cs_last_low != t0 + 75 || cs_frames - f0 != 1) begin
            errors++; $display("FAIL single_csn: got low %0d..%0d frames=%0d required %0d..%0d frames=1",
                               cs_fall - t0, cs_last_low - t0, cs_frames - f0, 1, 75);
        end
        checks++;
        if (strobe_err != se0) begin errors++; $display("FAIL single_strobes: got %0d bad strobe cycles required 0", strobe_err - se0); end
    endtask

    task automatic test_multi_byte();
        int t0, dc, rx_rd, i0, c0, f0;
        logic [7:0] e;
        tx_mem[0] = 8'h11; tx_mem[1] = 8'h22; tx_mem[2] = 8'h33; miso_one = 1'b1;
        for (int k = 0; k < 3; k++) exp_rx.push_back(8'hFF);
        rx_rd = rx_obs.size(); i0 = idx_obs.size(); c0 = txd_chg.size(); f0 = cs_frames;
        start_xfer(4'd3, t0);
        wait_done(500, dc);
        $display("xfer multi: len=3 start=%0d done=%0d", t0, dc);
        checks++;
        if (dc - t0 != 210) begin errors++; $display("FAIL multi_latency: got %0d required 210", dc - t0); end
        checks++;
        if (rx_obs.size() - rx_rd != 3) begin errors++; $display("FAIL multi_rx_count: got %0d required 3", rx_obs.size() - rx_rd); end
        for (int k = 0; k < 3; k++) begin
            e = exp_rx.pop_front();
            checks++;
            if (rx_obs.size() <= rx_rd + k || rx_obs[rx_rd + k] !== e) begin
                errors++; $display("FAIL multi_rx_data[%0d]: required %h", k, e);
            end
            checks++;
            if (idx_obs.size() <= i0 + k || idx_obs[i0 + k] !== 4'(k) || txd_obs[i0 + k] !== tx_mem[k]) begin
                errors++; $display("FAIL multi_load[%0d]: required idx %0d data %h", k, k, tx_mem[k]);
            end
        end
        checks++;
        if (txd_chg.size() < c0 + 3 || txd_chg[c0] != t0 + 6 ||
            txd_chg[c0 + 1] - txd_chg[c0] != 67 || txd_chg[c0 + 2] - txd_chg[c0 + 1] != 67) begin
            errors++; $display("FAIL multi_txdata_hold: required change at +6 and holds of 67 cycles");
        end
        checks++;
        if (cs_frames - f0 != 1) begin errors++; $display("FAIL multi_frames: got %0d required 1", cs_frames - f0); end
    endtask

    task automatic test_len_zero_and_start_ignored();
        int t0, t1, dc, d0, f0, rx_rd, i0;
        logic bad;
        d0 = done_cnt; f0 = cs_frames; bad = 1'b0;
        start_xfer(4'd0, t0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.Busy !== 1'b0 || bus.CSn !== 1'b1) bad = 1'b1;
        end
        $display("xfer len0: start=%0d ignored", t0);
        checks++;
        if (bad || done_cnt != d0 || cs_frames != f0) begin
            errors++; $display("FAIL len_zero: busy/csn disturbed=%b dones=%0d frames=%0d required 0/0/0", bad, done_cnt - d0, cs_frames - f0);
        end
        tx_mem[0] = 8'h3C; tx_mem[1] = 8'hC3; miso_one = 1'b0;
        exp_rx.push_back(8'h3C); exp_rx.push_back(8'hC3);
        rx_rd = rx_obs.size(); i0 = idx_obs.size();
        start_xfer(4'd2, t0);
        repeat (30) @(negedge clk);
        start_xfer(4'd5, t1);
        wait_done(400, dc);
        $display("xfer ignore: len=2 start=%0d done=%0d extra start at %0d", t0, dc, t1);
        checks++;
        if (dc - t0 != 143) begin errors++; $display("FAIL ignore_latency: got %0d required 143", dc - t0); end
        checks++;
        if (idx_obs.size() - i0 != 2 || idx_obs[i0] !== 4'd0 || idx_obs[i0 + 1] !== 4'd1) begin
            errors++; $display("FAIL ignore_idx_seq: got %0d loads required idx 0,1", idx_obs.size() - i0);
        end
        for (int k = 0; k < 2; k++) begin
            logic [7:0] e;
            e = exp_rx.pop_front();
            checks++;
            if (rx_obs.size() <= rx_rd + k || rx_obs[rx_rd + k] !== e) begin
                errors++; $display("FAIL ignore_rx_data[%0d]: required %h", k, e);
            end
        end
    endtask

    task automatic test_stall();
        int t0, dc, rv, c0, rx_rd;
        logic bad;
        tx_mem[0] = 8'h5A; tx_mem[1] = 8'h96; miso_one = 1'b0;
        exp_rx.push_back(8'h5A); exp_rx.push_back(8'h96);
        c0 = txd_chg.size(); rx_rd = rx_obs.size(); rv = -1; bad = 1'b0;
        start_xfer(4'd2, t0);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.Rx_Valid) begin rv = cyc; break; end
        end
        force_busy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (bus.SCLK !== 1'b0 || bus.H2L_Sig || bus.L2H_Sig) bad = 1'b1;
            @(negedge clk);
        end
        force_busy = 1'b0;
        wait_done(400, dc);
        $display("xfer stall: len=2 start=%0d done=%0d", t0, dc);
        checks++;
        if (rv - t0 != 71) begin errors++; $display("FAIL stall_rx_valid_cycle: got %0d required 71", rv - t0); end
        checks++;
        if (bad) begin errors++; $display("FAIL stall_sclk: got activity during stall required none"); end
        checks++;
        if (txd_chg.size() < c0 + 2 || txd_chg[c0 + 1] - t0 != 83) begin
            errors++; $display("FAIL stall_next_load: required second Tx_Data change at +83");
        end
        checks++;
        if (dc - t0 != 153) begin errors++; $display("FAIL stall_latency: got %0d required 153", dc - t0); end
        for (int k = 0; k < 2; k++) begin
            logic [7:0] e;
            e = exp_rx.pop_front();
            checks++;
            if (rx_obs.size() <= rx_rd + k || rx_obs[rx_rd + k] !== e) begin
                errors++; $display("FAIL stall_rx_data[%0d]: required %h", k, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0, dc, n, rx0, d0;
        logic hit;
        logic [7:0] e;
        tx_mem[0] = 8'h6B; miso_one = 1'b0; n = 0; hit = 1'b0;
        start_xfer(4'd1, t0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.H2L_Sig || bus.L2H_Sig) n++;
            if (n == 5) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL midreset_reach: got %0d toggles required 5", n); end
        rx0 = rx_obs.size(); d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.CSn, bus.SCLK, bus.H2L_Sig, bus.L2H_Sig, bus.Busy} !== 5'b10000) begin
            errors++; $display("FAIL midreset_outputs: got %b required 10000",
                               {bus.CSn, bus.SCLK, bus.H2L_Sig, bus.L2H_Sig, bus.Busy});
        end
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        $display("xfer aborted: len=1 start=%0d reset at toggle 5", t0);
        checks++;
        if (rx_obs.size() != rx0 || done_cnt != d0) begin
            errors++; $display("FAIL midreset_no_done: got rx=%0d done=%0d required 0/0", rx_obs.size() - rx0, done_cnt - d0);
        end
        tx_mem[0] = 8'hE7;
        exp_rx.push_back(8'hE7);
        start_xfer(4'd1, t0);
        wait_done(300, dc);
        $display("xfer after reset: len=1 start=%0d done=%0d", t0, dc);
        checks++;
        if (dc - t0 != 76) begin errors++; $display("FAIL midreset_rerun_latency: got %0d required 76", dc - t0); end
        e = exp_rx.pop_front();
        checks++;
        if (rx_obs.size() != rx0 + 1 || rx_obs[rx0] !== e) begin
            errors++; $display("FAIL midreset_rerun_rx: required one byte %h", e);
        end
    endtask

    task automatic test_max_len();
        int t0, dc, rx_rd, i0, d0;
        logic bad_idx, bad_rx;
        logic [7:0] e;
        miso_one = 1'b0; bad_idx = 1'b0; bad_rx = 1'b0;
        for (int k = 0; k < 16; k++) tx_mem[k] = 8'($urandom_range(0, 255));
        for (int k = 0; k < 15; k++) exp_rx.push_back(tx_mem[k]);
        rx_rd = rx_obs.size(); i0 = idx_obs.size(); d0 = done_cnt;
        start_xfer(4'd15, t0);
        wait_done(1500, dc);
        $display("xfer max: len=15 start=%0d done=%0d", t0, dc);
        checks++;
        if (dc - t0 != 1014) begin errors++; $display("FAIL max_latency: got %0d required 1014", dc - t0); end
        checks++;
        if (rx_obs.size() - rx_rd != 15 || idx_obs.size() - i0 != 15 || done_cnt - d0 != 1) begin
            errors++; $display("FAIL max_counts: got rx=%0d loads=%0d done=%0d required 15/15/1",
                               rx_obs.size() - rx_rd, idx_obs.size() - i0, done_cnt - d0);
        end
        for (int k = 0; k < 15; k++) begin
            e = exp_rx.pop_front();
            if (idx_obs.size() <= i0 + k || idx_obs[i0 + k] !== 4'(k)) bad_idx = 1'b1;
            if (rx_obs.size() <= rx_rd + k || rx_obs[rx_rd + k] !== e) bad_rx = 1'b1;
        end
        checks++;
        if (bad_idx) begin errors++; $display("FAIL max_idx_seq: got non-sequential Byte_Idx required 0..14"); end
        checks++;
        if (bad_rx) begin errors++; $display("FAIL max_rx_data: got mismatching bytes required loopback of TX"); end
    endtask

    initial begin
        bus.Start = 1'b0;
        bus.Len   = 4'd0;
        for (int k = 0; k < 16; k++) tx_mem[k] = 8'h00;
        test_reset();
        test_single_loopback();
        test_multi_byte();
        test_len_zero_and_start_ignored();
        test_stall();
        test_reset_mid();
        test_max_len();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
Transaction sequencer for the SPI byte transmitter (the En / H2L_Sig / L2H_Sig / Busy_Sig / Data byte module) on the SPI master path, mode 0 (SCLK idle low).
- Runs multi-byte chip-select-framed transfers.
- Generates SCLK and the one-cycle H2L/L2H edge strobes.
- Fetches each TX byte from the host by index and loads it into the byte transmitter.
- Samples MISO into RX bytes.
- Owns the bus from Start to Done.

Parameters:
CLK_DIV, 4, CLK cycles per SCLK half-period; legal range ≥2.
LEN_W, 4, width of byte-count and byte-index fields; maximum transfer is 2^LEN_W-1 bytes.
CS_GAP, 4, CLK cycles of CSn setup before the first SCLK edge and of hold after the last.

Ports:
CLK  in  1  system clock
RSTn  in  1  asynchronous active-low reset
Start  in  1  one-cycle transfer request; sampled only in IDLE
Len  in  LEN_W  byte count, sampled with Start; 0 = request ignored
Byte_Idx  out  LEN_W  index of the next TX byte the host must present
Byte_In  in  8  TX byte for Byte_Idx; sampled in LOAD
Rx_Data  out  8  last received byte
Rx_Valid  out  1  one-cycle strobe, Rx_Data new
Busy  out  1  transfer in progress
Done  out  1  one-cycle end-of-transfer strobe
CSn  out  1  slave select, active low
SCLK  out  1  serial clock
MISO  in  1  serial data in
Tx_En  out  1  byte-transmitter start
Tx_Data  out  8  byte-transmitter data; stable for the whole byte
H2L_Sig  out  1  SCLK falling-edge strobe
L2H_Sig  out  1  SCLK rising-edge strobe
Tx_Busy  in  1  byte-transmitter busy

Behaviour:
- Reset: state IDLE; CSn=1; SCLK=0; Busy, Done, Rx_Valid, Tx_En, H2L_Sig and L2H_Sig all 0; Tx_Data=0; Rx_Data=0; Byte_Idx=0. Reset takes effect immediately, including mid-transfer: CSn deasserts at once and no Done is generated.
- IDLE: on Start && Len!=0, latch Len and go to CS_SETUP. Start while not IDLE is ignored.
- CS_SETUP: CSn=0, Busy=1. Hold for CS_GAP cycles, then go to LOAD.
- LOAD (1 cycle): Tx_Data<=Byte_In, then go to EN.
- EN (1 cycle): Tx_En=1, then go to SHIFT.
- SHIFT: a half-period counter runs 0..CLK_DIV-1. On each wrap, SCLK toggles.
  - 0→1 toggle: L2H_Sig=1 for 1 cycle, and MISO is shifted MSB-first into the RX shift register in that same cycle.
  - 1→0 toggle: H2L_Sig=1 for 1 cycle.
  - After 16 toggles (8 falling edges), go to BYTE_END. SCLK is low at that point.
- BYTE_END: Rx_Data<=shift register and Rx_Valid=1, both exactly once, in the first BYTE_END cycle. Remain in BYTE_END while Tx_Busy=1 (stall, SCLK held low).
  - If more bytes remain: Byte_Idx+1, go to LOAD.
  - Otherwise go to CS_HOLD.
- CS_HOLD: CS_GAP cycles with CSn=0, then go to DONE.
- DONE (1 cycle): CSn=1, Done=1, Busy=0, Byte_Idx=0, then go to IDLE.
- Byte cost: 16*CLK_DIV+3 cycles.
- Start→Done latency (no stall): 1+CS_GAP+Len*(16*CLK_DIV+3)+CS_GAP cycles.
- Tx_Data is unchanged from LOAD until the next LOAD.
- H2L_Sig and L2H_Sig are never high in the same cycle, and never high outside SHIFT.
- Byte_Idx is valid and stable in the cycle before LOAD and during LOAD.
- Len=2^LEN_W-1 runs with no index wrap; the last Byte_Idx is Len-1.

Decomposition:
- Package spi_pkg:
  - state encoding (IDLE, CS_SETUP, LOAD, EN, SHIFT, BYTE_END, CS_HOLD, DONE)
  - SPI mode constant CPOL=0
  - byte width 8
- Sub-module spi_sclk_gen: half-period counter, SCLK register, H2L/L2H strobes, edge count.
  - Inputs: run, clear.
  - Outputs: SCLK, H2L_Sig, L2H_Sig, byte_last.
- The FSM, index counter and RX shifter stay in spi_xfer_ctrl.

Test Plan:
1. CLK_DIV=4, CS_GAP=4, Start with Len=1, Byte_In=8'hA5, MISO looped to MOSI of the attached byte transmitter:
   - Done at cycle 76; Rx_Data=8'hA5 with one Rx_Valid.
   - Exactly 8 H2L_Sig and 8 L2H_Sig pulses.
   - CSn low from cycle 1 to cycle 75.
2. Len=3, host returns 8'h11/8'h22/8'h33 for Byte_Idx 0/1/2, MISO tied 1:
   - Three Rx_Valid pulses, each with Rx_Data=8'hFF.
   - Tx_Data holds each value for 67 cycles.
   - Single CSn frame; Done after 1+4+201+4=210 cycles.
3. Len=0 with Start → no state change: Busy=0, CSn=1, no Done. Start pulsed mid-transfer → ignored; Byte_Idx sequence unaffected.
4. Tx_Busy forced high for 10 cycles in BYTE_END → SCLK stays 0, no edge strobes, next LOAD delayed by 10 cycles, Done delayed by 10 cycles.
5. RSTn asserted during the 5th SHIFT toggle → CSn=1, SCLK=0 and all strobes 0 in that cycle; no Done or Rx_Valid. A new Start after release runs a full, correct transfer.
6. Len=15 (LEN_W=4) → Byte_Idx steps 0..14 with no wrap; 15 Rx_Valid pulses; 1 Done.
